// File: rtl/intr_ctrl_pkg.sv
// rtl/intr_ctrl_pkg.sv - shared constants for the interrupt controller
//
// Purpose: controller state encoding and the vector-width helper used by
//          intr_ctrl and intr_prio_enc.
// Contents:
//   IDLE, PEND, SERV  controller state constants (2-bit)
//   vec_width(n)      ceil(log2(n)) for n in 2..16
package intr_ctrl_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] PEND = 2'b01;
  localparam logic [1:0] SERV = 2'b10;

  function automatic int vec_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 5; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// rtl/intr_prio_enc.sv - rotating-start priority encoder
//
// Purpose: returns the first set request bit found when scanning upward
//          from start and wrapping past N-1 back to 0.
// Ports:
//   req    in   N   request vector
//   start  in   VW  index searched first (must be < N)
//   idx    out  VW  index of the winning request (0 when none)
//   valid  out  1   at least one request is set
module intr_prio_enc
  import intr_ctrl_pkg::*;
#(
  parameter int N  = 2,
  parameter int VW = vec_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [VW-1:0] start,
  output logic [VW-1:0] idx,
  output logic          valid
);

  int j;

  // Scan from the farthest offset down to offset 0 so the bit nearest to
  // start is the last assignment and therefore wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(start) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        idx   = VW'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - masked, prioritised interrupt controller with EOI hold-off
//
// Purpose: arbitrates sticky device interrupt lines, raises cpuIntr, hands the
//          winner's vector to the CPU on acknowledge, pulses that device's ack
//          and blocks new interrupts until end-of-interrupt.
// Build option: INTR_CTRL_RR_EN selects round-robin priority (search starts
//          one past the last source served); otherwise index 0 is highest.
// Ports:
//   clk      in   1   clock, rising edge
//   rst      in   1   asynchronous active-low reset
//   devIntr  in   N   sticky interrupt levels from devices
//   devAck   out  N   one-cycle ack pulse to the granted device
//   cfgWe    in   1   mask write enable
//   cfgMask  in   N   mask write data (1 = masked)
//   mask     out  N   current mask register
//   cpuIntr  out  1   interrupt request to CPU
//   cpuIntA  in   1   CPU interrupt acknowledge pulse
//   cpuVec   out  VW  vector of the interrupt being served
//   cpuEoi   in   1   CPU end-of-interrupt pulse
//   busy     out  1   controller not idle
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int N  = 2,
  parameter int VW = vec_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  devIntr,
  output logic [N-1:0]  devAck,
  input  logic          cfgWe,
  input  logic [N-1:0]  cfgMask,
  output logic [N-1:0]  mask,
  output logic          cpuIntr,
  input  logic          cpuIntA,
  output logic [VW-1:0] cpuVec,
  input  logic          cpuEoi,
  output logic          busy
);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [VW-1:0] id;
  logic [N-1:0]  eligible;
  logic [VW-1:0] start;
  logic [VW-1:0] win_idx;
  logic          win_valid;

  assign eligible = devIntr & ~mask;

`ifdef INTR_CTRL_RR_EN
  logic [VW-1:0] last;

  assign start = (last == VW'(N - 1)) ? '0 : last + VW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= '0;
    end else if (state == SERV && cpuEoi) begin
      last <= id;
    end
  end
`else
  assign start = '0;
`endif

  intr_prio_enc #(.N(N), .VW(VW)) u_prio_enc (
    .req   (eligible),
    .start (start),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // cpuIntA is checked before the withdraw test so an acknowledge in the same
  // cycle as the source being masked still completes the grant.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (win_valid) state_nx = PEND;
      PEND: begin
        if (cpuIntA)            state_nx = SERV;
        else if (!eligible[id]) state_nx = IDLE;
      end
      SERV:    if (cpuEoi) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so cpuIntr and busy line up
  // with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mask    <= '0;
      id      <= '0;
      cpuIntr <= 1'b0;
      cpuVec  <= '0;
      devAck  <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      cpuIntr <= (state_nx == PEND);
      busy    <= (state_nx != IDLE);
      devAck  <= '0;
      if (cfgWe) mask <= cfgMask;
      if (state == IDLE && win_valid) id <= win_idx;
      if (state == PEND && cpuIntA) begin
        cpuVec <= id;
        devAck <= N'(1) << id;
      end
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed and randomized bench for intr_ctrl
module tb_intr_ctrl;

  localparam int N  = 4;
  localparam int VW = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  devIntr;
  logic [N-1:0]  devAck;
  logic          cfgWe;
  logic [N-1:0]  cfgMask;
  logic [N-1:0]  mask;
  logic          cpuIntr;
  logic          cpuIntA;
  logic [VW-1:0] cpuVec;
  logic          cpuEoi;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model: "waiting for CPU" / "CPU serving" flags, the chosen
  // source, the mask, the last vector handed out and the expected ack.
  bit            m_wait;
  bit            m_serving;
  int            m_src;
  logic [N-1:0]  m_mask;
  int            m_vec;
  logic [N-1:0]  m_ack;
  int            m_last;
  logic [N-1:0]  ack_h1;
  logic [N-1:0]  ack_h2;

  intr_ctrl #(.N(N), .VW(VW)) dut (
    .clk     (clk),
    .rst     (rst),
    .devIntr (devIntr),
    .devAck  (devAck),
    .cfgWe   (cfgWe),
    .cfgMask (cfgMask),
    .mask    (mask),
    .cpuIntr (cpuIntr),
    .cpuIntA (cpuIntA),
    .cpuVec  (cpuVec),
    .cpuEoi  (cpuEoi),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] e, input int first);
    for (int k = 0; k < N; k++) begin
      if (e[(first + k) % N]) return (first + k) % N;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_wait    = 0;
    m_serving = 0;
    m_src     = 0;
    m_mask    = '0;
    m_vec     = 0;
    m_ack     = '0;
    m_last    = 0;
    ack_h1    = '0;
    ack_h2    = '0;
  endtask

  task automatic compare_all();
    chk("cpuIntr", 32'(cpuIntr), 32'(m_wait));
    chk("busy",    32'(busy),    32'(m_wait || m_serving));
    chk("cpuVec",  32'(cpuVec),  32'(m_vec));
    chk("devAck",  32'(devAck),  32'(m_ack));
    chk("mask",    32'(mask),    32'(m_mask));
  endtask

  // One clock: drive inputs, let the edge pass, advance the model, compare.
  // A device drops its latch on the edge after it saw its ack, which is why
  // the clear uses the ack expected two compares ago.
  task automatic step(input logic [N-1:0] raise, input logic we, input logic [N-1:0] wmask,
                      input logic inta, input logic eoi);
    logic [N-1:0] elig;
    int           first;
    devIntr = (devIntr & ~ack_h2) | raise;
    cfgWe   = we;
    cfgMask = wmask;
    cpuIntA = inta;
    cpuEoi  = eoi;
    @(posedge clk);
    #1;
    elig  = devIntr & ~m_mask;
    m_ack = '0;
    if (we) m_mask = wmask;
`ifdef INTR_CTRL_RR_EN
    first = (m_last + 1) % N;
`else
    first = 0;
`endif
    if (m_wait) begin
      if (inta) begin
        m_wait    = 0;
        m_serving = 1;
        m_vec     = m_src;
        m_ack[m_src] = 1'b1;
      end else if (!elig[m_src]) begin
        m_wait = 0;
      end
    end else if (m_serving) begin
      if (eoi) begin
        m_serving = 0;
        m_last    = m_src;
      end
    end else if (elig != '0) begin
      m_src  = pick(elig, first);
      m_wait = 1;
    end
    compare_all();
    ack_h2 = ack_h1;
    ack_h1 = m_ack;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic serve_one();
    idle(1);
    step('0, 1'b0, '0, 1'b1, 1'b0);
    idle(2);
    step('0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [N-1:0] r_raise;
    logic [N-1:0] r_mask;
    logic         r_we;
    logic         r_inta;
    logic         r_eoi;

    rst = 1'b0; devIntr = '0; cfgWe = 1'b0; cfgMask = '0; cpuIntA = 1'b0; cpuEoi = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;

    // single source 1
    step(4'b0010, 1'b0, '0, 1'b0, 1'b0);
    chk("single_intr", 32'(cpuIntr), 32'd1);
    idle(1);
    step('0, 1'b0, '0, 1'b1, 1'b0);
    chk("single_vec", 32'(cpuVec), 32'd1);
    chk("single_ack", 32'(devAck), 32'b0010);
    idle(1);
    chk("single_ack_drop", 32'(devAck), 32'd0);
    step('0, 1'b0, '0, 1'b0, 1'b1);
    chk("single_busy", 32'(busy), 32'd0);
    idle(2);

    // simultaneous requests, two rounds
    step(4'b0011, 1'b0, '0, 1'b0, 1'b0);
    serve_one();
    serve_one();
    idle(1);
    step(4'b0011, 1'b0, '0, 1'b0, 1'b0);
    serve_one();
    serve_one();
    idle(2);

    // masking: masked source never requests, unmask raises one cycle later
    step('0, 1'b1, 4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, '0, 1'b0, 1'b0);
    idle(2);
    chk("masked_quiet", 32'(cpuIntr), 32'd0);
    step('0, 1'b1, 4'b0000, 1'b0, 1'b0);
    idle(1);
    chk("unmask_intr", 32'(cpuIntr), 32'd1);
    // mask while pending withdraws the request
    step('0, 1'b1, 4'b0001, 1'b0, 1'b0);
    idle(1);
    chk("withdraw_intr", 32'(cpuIntr), 32'd0);
    idle(1);
    // unmask, then acknowledge together with a mask write
    step('0, 1'b1, 4'b0000, 1'b0, 1'b0);
    idle(1);
    step('0, 1'b1, 4'b1000, 1'b1, 1'b0);
    idle(2);
    step('0, 1'b1, 4'b0000, 1'b0, 1'b1);
    idle(2);

    // spurious handshakes
    step('0, 1'b0, '0, 1'b1, 1'b0);
    step(4'b0100, 1'b0, '0, 1'b0, 1'b1);
    step('0, 1'b0, '0, 1'b0, 1'b1);
    chk("eoi_in_pend", 32'(cpuIntr), 32'd1);
    step('0, 1'b0, '0, 1'b1, 1'b0);
    idle(2);
    step('0, 1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // reset in the ack cycle, between clock edges
    step(4'b0100, 1'b0, '0, 1'b0, 1'b0);
    idle(1);
    step('0, 1'b0, '0, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_intr", 32'(cpuIntr), 32'd0);
    chk("rst_ack",  32'(devAck),  32'd0);
    chk("rst_busy", 32'(busy),    32'd0);
    model_reset();
    #1;
    rst = 1'b1;
    idle(1);
    chk("rearb_intr", 32'(cpuIntr), 32'd1);
    serve_one();
    idle(2);

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      r_raise = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      r_we    = ($urandom_range(0, 9) == 0);
      r_mask  = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      r_inta  = ($urandom_range(0, 2) == 0);
      r_eoi   = ($urandom_range(0, 3) == 0);
      step(r_raise, r_we, r_mask, r_inta, r_eoi);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Interrupt controller between the toy IO devices and the CPU. It collects the sticky interrupt lines from N devices, applies a software mask, and picks one source by priority. It raises a single CPU interrupt, returns the winner's vector on CPU acknowledge, and pulses that device's ack to clear its latch. It then holds off further interrupts until the CPU signals end-of-interrupt (EOI).

Parameters:
N, 2, number of interrupt sources (device 0 .. N-1); legal range 2..16
VW, 1, vector width; must equal ceil(log2(N))

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
devIntr  input  N  sticky interrupt level from each device
devAck  output  N  one-cycle ack pulse to the granted device
cfgWe  input  1  mask register write enable
cfgMask  input  N  mask write data; bit=1 masks the source
mask  output  N  current mask register
cpuIntr  output  1  interrupt request to CPU (level)
cpuIntA  input  1  CPU interrupt acknowledge (single-cycle pulse)
cpuVec  output  VW  vector (source index) of the interrupt being served
cpuEoi  input  1  CPU end-of-interrupt (single-cycle pulse)
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; mask=0 (all enabled); id=0.
  - cpuIntr=0, cpuVec=0, devAck=0, busy=0.
- All outputs are registered.
- eligible = devIntr & ~mask.
- State IDLE:
  - If eligible != 0: latch id = lowest set index (fixed priority, 0 highest), go to PEND.
  - cpuIntr rises the cycle after eligible is first seen.
- State PEND:
  - cpuIntr=1.
  - On cpuIntA: go to SERV; cpuVec=id and devAck[id]=1 for exactly that one following cycle.
  - If eligible[id] falls before cpuIntA (source masked): withdraw, cpuIntr=0, return to IDLE.
  - If cpuIntA arrives in the same cycle as the source is masked, cpuIntA wins.
  - Grant is not pre-empted by a higher-priority source arriving during PEND.
- State SERV:
  - cpuIntr=0; cpuVec holds id; devAck returns to 0 after the single pulse.
  - On cpuEoi: go to IDLE; re-arbitration is possible on the cycle after.
  - Devices clear their latch one cycle after ack, so the served source is already low when IDLE resumes.
- Ignored inputs:
  - cpuIntA outside PEND is ignored.
  - cpuEoi outside SERV is ignored; no state change, no ack.
- Mask register:
  - cfgWe writes mask in any state; the new value is visible to eligible the next cycle.
  - cfgWe and cpuIntA in the same cycle: the write lands and the grant still completes.
- Minimum latency, device assert to cpuIntr: 1 cycle. cpuIntA to devAck: 1 cycle.
- Reset mid-operation drops cpuIntr and devAck immediately. Any device latch not yet acked stays set and is re-arbitrated after reset.

Optional Feature:
- Macro: INTR_CTRL_RR_EN.
- Defined: round-robin priority. A last-served pointer (VW bits, reset 0) updates on each EOI. Search starts at (last+1) mod N and wraps, so no source is starved.
- Undefined: fixed priority, lowest index wins; the pointer logic is not built.

Decomposition:
- Package intr_ctrl_pkg holds:
  - State encoding: IDLE=2'b00, PEND=2'b01, SERV=2'b10.
  - The VW computation constant.
- One sub-module, intr_prio_enc: N-bit request plus start index in; one-hot-free index and valid out.
  - With INTR_CTRL_RR_EN undefined, the start index is tied to 0.

Test Plan:
- Single source: devIntr=2'b10, mask=0 → cpuIntr=1 next cycle; cpuIntA → cpuVec=1 and devAck=2'b10 for one cycle; cpuEoi → busy=0.
- Simultaneous requests: devIntr=2'b11 → vector 0 served first; after EOI, vector 1 is served (fixed priority). With INTR_CTRL_RR_EN defined and a second round of 2'b11, the order is 1 then 0.
- Masking:
  - Write mask=2'b01 with devIntr=2'b01 → cpuIntr stays 0.
  - Write mask=0 → cpuIntr=1 one cycle later.
  - Mask source 0 during PEND → cpuIntr drops, returns to IDLE, no devAck.
- Spurious handshakes: cpuIntA in IDLE and cpuEoi in PEND → no devAck, state unchanged, cpuIntr unaffected.
- Reset mid-SERV: assert rst=0 asynchronously between clock edges → cpuIntr=0, devAck=0, busy=0 immediately. After release, the still-pending device is re-requested.
